branch_pc_unit: RTL and testbench

- Program-counter stage directly downstream of the control unit.
- Consumes the one-hot branch/call/return strobes (b, br, bz, bnz, bcy, bncy, bs, bns, bv, bnv, Call, Ret) and the ALU status flags.
- Holds the architectural PC, the flag register and a hardware return-address stack (RAS). Produces the next fetch address each cycle.

---
 rtl/kgp_pc_pkg.sv | 40 ++++
 rtl/branch_pc_unit_if.sv | 51 +++++
 rtl/kgp_ras.sv | 73 +++++++
 rtl/branch_pc_unit.sv | 119 +++++++++++
 tb/tb_branch_pc_unit.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/kgp_pc_pkg.sv
// Shared definitions for the PC stage: flag bit positions, branch conditions, PC increment.
// Condition evaluation is shared here so the PC stage and any future users agree on it.
package kgp_pc_pkg;

    localparam int FLAG_C = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_S = 1;
    localparam int FLAG_V = 0;

    localparam int PC_INC = 4;

    typedef enum logic [2:0] {
        COND_Z,
        COND_NZ,
        COND_CY,
        COND_NCY,
        COND_S,
        COND_NS,
        COND_V,
        COND_NV
    } cond_e;

    function automatic logic cond_holds(input cond_e cond, input logic [3:0] flag_vec);
        logic hit;
        hit = 1'b0;
        case (cond)
            COND_Z:   hit =  flag_vec[FLAG_Z];
            COND_NZ:  hit = !flag_vec[FLAG_Z];
            COND_CY:  hit =  flag_vec[FLAG_C];
            COND_NCY: hit = !flag_vec[FLAG_C];
            COND_S:   hit =  flag_vec[FLAG_S];
            COND_NS:  hit = !flag_vec[FLAG_S];
            COND_V:   hit =  flag_vec[FLAG_V];
            COND_NV:  hit = !flag_vec[FLAG_V];
            default:  hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/branch_pc_unit_if.sv
// Bundle between the control unit / ALU and the PC stage.
// master: control side driving strobes and targets; slave: the PC stage.
interface branch_pc_unit_if #(
    parameter int PC_W      = 32,
    parameter int RAS_DEPTH = 4
);
    localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

    logic             instr_valid;
    logic             stall;
    logic             b;
    logic             br;
    logic             bz;
    logic             bnz;
    logic             bcy;
    logic             bncy;
    logic             bs;
    logic             bns;
    logic             bv;
    logic             bnv;
    logic             Call;
    logic             Ret;
    logic [PC_W-1:0]  imm_target;
    logic [PC_W-1:0]  reg_target;
    logic             flag_we;
    logic             alu_c;
    logic             alu_z;
    logic             alu_s;
    logic             alu_v;

    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  pc_plus4;
    logic [3:0]       flags;
    logic             taken;
    logic [CNT_W-1:0] ras_count;
    logic             ras_overflow;
    logic             ras_underflow;

    modport master (
        output instr_valid, stall, b, br, bz, bnz, bcy, bncy, bs, bns, bv, bnv, Call, Ret,
        output imm_target, reg_target, flag_we, alu_c, alu_z, alu_s, alu_v,
        input  pc, pc_plus4, flags, taken, ras_count, ras_overflow, ras_underflow
    );

    modport slave (
        input  instr_valid, stall, b, br, bz, bnz, bcy, bncy, bs, bns, bv, bnv, Call, Ret,
        input  imm_target, reg_target, flag_we, alu_c, alu_z, alu_s, alu_v,
        output pc, pc_plus4, flags, taken, ras_count, ras_overflow, ras_underflow
    );

endinterface

// File: rtl/kgp_ras.sv
// Circular hardware return-address stack: push overwrites the oldest entry when full,
// pop saturates at empty and pulses underflow.
module kgp_ras #(
    parameter int PC_W  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [PC_W-1:0]            push_data,
    output logic [PC_W-1:0]            top,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             overflow_reg;
    logic             underflow_reg;
    logic             full;
    logic             do_push;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    // Ret beats Call when both are presented, so a pop suppresses the push.
    assign do_push = push && !pop;

    // The top entry must be available in the same cycle as the Ret, so the
    // array is read asynchronously; at this depth it maps to plain registers.
    assign top = mem[ptr_reg - PTR_W'(1)];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg       <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            underflow_reg <= pop && empty;
            if (pop) begin
                if (!empty) begin
                    ptr_reg   <= ptr_reg - PTR_W'(1);
                    count_reg <= count_reg - CNT_W'(1);
                end
            end else if (do_push) begin
                // When full, ptr already addresses the oldest slot.
                ptr_reg <= ptr_reg + PTR_W'(1);
                if (full) begin
                    overflow_reg <= 1'b1;
                end else begin
                    count_reg <= count_reg + CNT_W'(1);
                end
            end
        end
    end

    assign count     = count_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule

// File: rtl/branch_pc_unit.sv
// Program-counter stage: PC mux, branch-condition evaluation, flag register and RAS.
// Optional KGP_FLAG_FWD_EN forwards same-cycle ALU flags into conditional branches.
module branch_pc_unit
    import kgp_pc_pkg::*;
#(
    parameter int              PC_W      = 32,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input logic             clk,
    input logic             rst_n,
    branch_pc_unit_if.slave bus
);
    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

    logic [PC_W-1:0] pc_reg;
    logic [3:0]      flags_reg;
    logic            taken_reg;

    logic [PC_W-1:0] pc_plus4;
    logic [PC_W-1:0] pc_next;
    logic            redirect;
    logic            want_push;
    logic            want_pop;
    logic            active;
    logic [3:0]      alu_flags;
    logic [3:0]      eval_flags;
    logic            has_cond;
    cond_e           cond_sel;
    logic            cond_hit;

    logic [PC_W-1:0] ras_top;
    logic            ras_empty;

    assign active    = bus.instr_valid && !bus.stall;
    assign pc_plus4  = pc_reg + PC_W'(PC_INC);
    assign alu_flags = {bus.alu_c, bus.alu_z, bus.alu_s, bus.alu_v};

`ifdef KGP_FLAG_FWD_EN
    assign eval_flags = bus.flag_we ? alu_flags : flags_reg;
`else
    assign eval_flags = flags_reg;
`endif

    always_comb begin
        has_cond = 1'b1;
        cond_sel = COND_Z;
        if      (bus.bz)   cond_sel = COND_Z;
        else if (bus.bnz)  cond_sel = COND_NZ;
        else if (bus.bcy)  cond_sel = COND_CY;
        else if (bus.bncy) cond_sel = COND_NCY;
        else if (bus.bs)   cond_sel = COND_S;
        else if (bus.bns)  cond_sel = COND_NS;
        else if (bus.bv)   cond_sel = COND_V;
        else if (bus.bnv)  cond_sel = COND_NV;
        else               has_cond = 1'b0;
    end

    assign cond_hit = has_cond && cond_holds(cond_sel, eval_flags);

    // An empty-stack Ret still counts as a redirect even though it falls through.
    always_comb begin
        pc_next   = pc_plus4;
        redirect  = 1'b0;
        want_push = 1'b0;
        want_pop  = 1'b0;
        if (bus.Ret) begin
            want_pop = 1'b1;
            redirect = 1'b1;
            if (!ras_empty) pc_next = ras_top & ALIGN_MASK;
        end else if (bus.Call) begin
            want_push = 1'b1;
            redirect  = 1'b1;
            pc_next   = bus.imm_target & ALIGN_MASK;
        end else if (bus.br) begin
            redirect = 1'b1;
            pc_next  = bus.reg_target & ALIGN_MASK;
        end else if (bus.b || cond_hit) begin
            redirect = 1'b1;
            pc_next  = bus.imm_target & ALIGN_MASK;
        end
    end

    kgp_ras #(
        .PC_W  (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (active && want_push),
        .pop       (active && want_pop),
        .push_data (pc_plus4),
        .top       (ras_top),
        .empty     (ras_empty),
        .count     (bus.ras_count),
        .overflow  (bus.ras_overflow),
        .underflow (bus.ras_underflow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg    <= RESET_PC;
            flags_reg <= '0;
            taken_reg <= 1'b0;
        end else if (active) begin
            pc_reg    <= pc_next;
            taken_reg <= redirect;
            if (bus.flag_we) flags_reg <= alu_flags;
        end else begin
            taken_reg <= 1'b0;
        end
    end

    assign bus.pc       = pc_reg;
    assign bus.pc_plus4 = pc_plus4;
    assign bus.flags    = flags_reg;
    assign bus.taken    = taken_reg;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit with hand-computed expectations; honours KGP_FLAG_FWD_EN.
module tb_branch_pc_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    branch_pc_unit_if #(.PC_W(32), .RAS_DEPTH(4)) bus ();

    branch_pc_unit #(
        .PC_W      (32),
        .RAS_DEPTH (4),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
        $display("check %-14s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        bus.b = 0; bus.br = 0; bus.bz = 0; bus.bnz = 0; bus.bcy = 0; bus.bncy = 0;
        bus.bs = 0; bus.bns = 0; bus.bv = 0; bus.bnv = 0; bus.Call = 0; bus.Ret = 0;
        bus.flag_we = 0; bus.alu_c = 0; bus.alu_z = 0; bus.alu_s = 0; bus.alu_v = 0;
    endtask

    task automatic do_call(input logic [31:0] tgt);
        clear_strobes();
        bus.Call = 1; bus.imm_target = tgt;
        tick();
    endtask

    task automatic do_ret();
        clear_strobes();
        bus.Ret = 1;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 0;
        bus.instr_valid = 0; bus.stall = 0;
        bus.imm_target = 0; bus.reg_target = 0;
        clear_strobes();
        tick(); tick();

        check("rst_pc",    bus.pc, 32'h0);
        check("rst_flags", 32'(bus.flags), 32'h0);
        check("rst_taken", 32'(bus.taken), 32'h0);
        check("rst_count", 32'(bus.ras_count), 32'h0);
        check("rst_ovf",   32'(bus.ras_overflow), 32'h0);
        check("rst_unf",   32'(bus.ras_underflow), 32'h0);

        rst_n = 1;
        bus.instr_valid = 1;
        tick(); check("seq_pc4", bus.pc, 32'h4); check("seq_tk4", 32'(bus.taken), 32'h0);
        tick(); check("seq_pc8", bus.pc, 32'h8);
        tick(); check("seq_pcC", bus.pc, 32'hC); check("seq_tkC", 32'(bus.taken), 32'h0);
        check("pc_plus4", bus.pc_plus4, 32'h10);

        // Load Z, then branch on it
        bus.flag_we = 1; bus.alu_z = 1;
        tick(); check("fz_pc", bus.pc, 32'h10); check("fz_flags", 32'(bus.flags), 32'h4);
        clear_strobes(); bus.bz = 1; bus.imm_target = 32'h40;
        tick(); check("bz_pc", bus.pc, 32'h40); check("bz_taken", 32'(bus.taken), 32'h1);
        clear_strobes(); bus.bnz = 1; bus.imm_target = 32'h80;
        tick(); check("bnz_pc", bus.pc, 32'h44); check("bnz_taken", 32'(bus.taken), 32'h0);

        // Single Call/Ret
        clear_strobes(); bus.b = 1; bus.imm_target = 32'h20;
        tick(); check("b_pc", bus.pc, 32'h20); check("b_taken", 32'(bus.taken), 32'h1);
        do_call(32'h100);
        check("call_pc", bus.pc, 32'h100); check("call_cnt", 32'(bus.ras_count), 32'h1);
        do_ret();
        check("ret_pc", bus.pc, 32'h24); check("ret_cnt", 32'(bus.ras_count), 32'h0);
        check("ret_taken", 32'(bus.taken), 32'h1);

        // Five nested calls into a 4-deep stack
        do_call(32'h1000); do_call(32'h2000); do_call(32'h3000); do_call(32'h4000);
        check("n4_cnt", 32'(bus.ras_count), 32'h4); check("n4_ovf", 32'(bus.ras_overflow), 32'h0);
        do_call(32'h5000);
        check("n5_pc", bus.pc, 32'h5000);
        check("n5_cnt", 32'(bus.ras_count), 32'h4); check("n5_ovf", 32'(bus.ras_overflow), 32'h1);
        do_ret(); check("r1_pc", bus.pc, 32'h4004); check("r1_cnt", 32'(bus.ras_count), 32'h3);
        do_ret(); check("r2_pc", bus.pc, 32'h3004);
        do_ret(); check("r3_pc", bus.pc, 32'h2004);
        do_ret(); check("r4_pc", bus.pc, 32'h1004); check("r4_cnt", 32'(bus.ras_count), 32'h0);
        check("r4_unf", 32'(bus.ras_underflow), 32'h0);
        do_ret();
        check("r5_pc", bus.pc, 32'h1008); check("r5_unf", 32'(bus.ras_underflow), 32'h1);
        check("r5_taken", 32'(bus.taken), 32'h1); check("r5_cnt", 32'(bus.ras_count), 32'h0);
        clear_strobes();
        tick(); check("post_unf", 32'(bus.ras_underflow), 32'h0); check("post_pc", bus.pc, 32'h100C);
        check("ovf_sticky", 32'(bus.ras_overflow), 32'h1);

        // Stall holds everything, then masked br target
        bus.br = 1; bus.reg_target = 32'h203; bus.stall = 1;
        tick(); check("stall_pc", bus.pc, 32'h100C); check("stall_tk", 32'(bus.taken), 32'h0);
        bus.stall = 0;
        tick(); check("br_pc", bus.pc, 32'h200); check("br_taken", 32'(bus.taken), 32'h1);

        // Same-cycle flag write and bcy
        clear_strobes(); bus.flag_we = 1;
        tick(); check("fclr_pc", bus.pc, 32'h204); check("fclr_flags", 32'(bus.flags), 32'h0);
        bus.alu_c = 1; bus.bcy = 1; bus.imm_target = 32'h300;
        tick();
`ifdef KGP_FLAG_FWD_EN
        check("bcy_pc", bus.pc, 32'h300); check("bcy_taken", 32'(bus.taken), 32'h1);
`else
        check("bcy_pc", bus.pc, 32'h208); check("bcy_taken", 32'(bus.taken), 32'h0);
`endif
        check("bcy_flags", 32'(bus.flags), 32'h8);

        // instr_valid low holds pc; misaligned and wrapping targets
        clear_strobes(); bus.instr_valid = 0; bus.b = 1; bus.imm_target = 32'h500;
        tick();
`ifdef KGP_FLAG_FWD_EN
        check("nv_pc", bus.pc, 32'h300);
`else
        check("nv_pc", bus.pc, 32'h208);
`endif
        bus.instr_valid = 1; bus.imm_target = 32'h3FF;
        tick(); check("mask_pc", bus.pc, 32'h3FC);
        bus.imm_target = 32'hFFFF_FFFE;
        tick(); check("top_pc", bus.pc, 32'hFFFF_FFFC); check("top_p4", bus.pc_plus4, 32'h0);
        clear_strobes();
        tick(); check("wrap_pc", bus.pc, 32'h0); check("wrap_tk", 32'(bus.taken), 32'h0);
        do_call(32'h800);
        check("c2_cnt", 32'(bus.ras_count), 32'h1);

        // Asynchronous reset mid-cycle
        #2 rst_n = 0;
        #1;
        check("arst_pc", bus.pc, 32'h0); check("arst_cnt", 32'(bus.ras_count), 32'h0);
        check("arst_ovf", 32'(bus.ras_overflow), 32'h0); check("arst_flags", 32'(bus.flags), 32'h0);
        check("arst_tk", 32'(bus.taken), 32'h0);
        #2 rst_n = 1;
        clear_strobes();
        tick(); check("rel_pc", bus.pc, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
